// File: rtl/mips_mem_responder.sv
// rtl/mips_mem_responder.sv - wait-state memory responder for the multi-cycle MIPS core
module mips_mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEPTH = 2 ** ADDR_W;

  state_t            state;
  state_t            state_nx;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] idx_q;
  logic [31:0]       wdata_q;
  logic              write_q;
  logic [31:0]       mem [0:DEPTH-1];

  logic              req;
  logic              req_err;
  logic              access;

  // Upper byte-address bits only select a wrapped alias of the same word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[31:ADDR_W+2];

  // Next-state decode; the array access happens on the edge leaving the last wait state.
  always_comb begin
    state_nx = state;
    req      = MemRead | MemWrite;
    req_err  = (addr[1:0] != 2'b00) | (MemRead & MemWrite);
    access   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_nx = req_err ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nx = DONE;
          access   = 1'b1;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State, wait counter, request capture, error flag and read-data register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      write_q <= 1'b0;
      err     <= 1'b0;
      rdata   <= 32'd0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (req) begin
            idx_q   <= addr[ADDR_W+1:2];
            wdata_q <= wdata;
            write_q <= MemWrite;
            err     <= req_err;
            cnt     <= 4'(LATENCY);
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (!write_q) begin
            rdata <= mem[idx_q];
          end
        end
        DONE: begin
          err <= 1'b0;
        end
        default: begin
          err <= 1'b0;
        end
      endcase
    end
  end

  // Array write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (access && write_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign ready = (state == DONE);
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_mips_mem_responder.sv
// tb/tb_mips_mem_responder.sv - randomized self-checking bench for mips_mem_responder
module tb_mips_mem_responder;

  localparam int LAT  = 2;
  localparam int LAT3 = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic [31:0] rdata;
  logic        ready, busy, err;
  logic        mem_read_3 = 1'b0, mem_write_3 = 1'b0;
  logic [31:0] addr_3 = 32'd0, wdata_3 = 32'd0;
  logic [31:0] rdata_3;
  logic        ready_3, busy_3, err_3;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_mem [int];
  logic [31:0] model_rdata = 32'd0;
  bit          model_rdata_known = 1'b1;

  always #5 clk = ~clk;

  mips_mem_responder #(.ADDR_W(8), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .MemRead(mem_read), .MemWrite(mem_write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .busy(busy), .err(err)
  );

  mips_mem_responder #(.ADDR_W(8), .LATENCY(LAT3)) dut3 (
    .clk(clk), .reset(reset), .MemRead(mem_read_3), .MemWrite(mem_write_3),
    .addr(addr_3), .wdata(wdata_3), .rdata(rdata_3), .ready(ready_3), .busy(busy_3), .err(err_3)
  );

  // One request: drive it for one edge, then observe the completion.
  // lat = edges after the accept edge until ready is seen (-1 on timeout).
  task automatic issue(input int which, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic e, output logic [31:0] q,
                       output bit busy_ok, output bit idle_after);
    @(negedge clk);
    if (which == 0) begin
      mem_read = rd; mem_write = wr; addr = a; wdata = d;
    end else begin
      mem_read_3 = rd; mem_write_3 = wr; addr_3 = a; wdata_3 = d;
    end
    @(posedge clk); #1;
    if (which == 0) begin
      mem_read = 1'b0; mem_write = 1'b0; addr = $urandom; wdata = $urandom;
    end else begin
      mem_read_3 = 1'b0; mem_write_3 = 1'b0; addr_3 = $urandom; wdata_3 = $urandom;
    end
    lat = -1; e = 1'bx; q = 32'hx; busy_ok = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (!((which == 0) ? busy : busy_3)) busy_ok = 1'b0;
      if ((which == 0) ? ready : ready_3) begin
        lat = k;
        e   = (which == 0) ? err : err_3;
        q   = (which == 0) ? rdata : rdata_3;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    if (which == 0) idle_after = !ready && !busy && !err;
    else            idle_after = !ready_3 && !busy_3 && !err_3;
  endtask

  // Reference behaviour for dut from the request alone; checks every observation.
  task automatic model_req(input string tag, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] d);
    int lat; logic e; logic [31:0] q; bit bok, idl;
    bit   exp_err = (a % 4 != 0) || (rd && wr);
    int   idx     = (a / 4) % 256;
    int   exp_lat = exp_err ? 0 : LAT + 1;
    issue(0, rd, wr, a, d, lat, e, q, bok, idl);
    n_checks++;
    if (lat !== exp_lat) begin
      n_fail++; $display("FAIL %s latency: got %0d expected %0d", tag, lat, exp_lat);
    end
    n_checks++;
    if (e !== exp_err) begin
      n_fail++; $display("FAIL %s err: got %b expected %b", tag, e, exp_err);
    end
    n_checks++;
    if (!bok || !idl) begin
      n_fail++; $display("FAIL %s busy/idle: busy_held=%b idle_after=%b expected 1 1", tag, bok, idl);
    end
    if (!exp_err && wr) begin
      model_mem[idx] = d;
    end else if (!exp_err && rd) begin
      if (model_mem.exists(idx)) begin
        model_rdata = model_mem[idx];
        model_rdata_known = 1'b1;
      end else begin
        model_rdata_known = 1'b0;
      end
    end
    if (model_rdata_known) begin
      n_checks++;
      if (q !== model_rdata) begin
        n_fail++; $display("FAIL %s rdata: got %h expected %h", tag, q, model_rdata);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({ready, busy, err, rdata, ready_3, busy_3, err_3, rdata_3} !== 70'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %b %b %b %h expected all zero", ready, busy, err, rdata);
    end
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (busy !== 1'b0 || ready !== 1'b0) begin
        n_fail++; $display("FAIL idle_quiet cycle %0d: busy=%b ready=%b expected 0 0", k, busy, ready);
      end
    end
  endtask

  task automatic test_write_read;
    model_req("write_0x10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    model_req("read_0x10", 1'b1, 1'b0, 32'h10, 32'h0);
    n_checks++;
    if (rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL read_0x10_value: got %h expected deadbeef", rdata);
    end
  endtask

  task automatic test_wrap;
    model_req("write_0x400", 1'b0, 1'b1, 32'h400, 32'h12345678);
    model_req("read_0x0", 1'b1, 1'b0, 32'h0, 32'h0);
    model_req("write_0x3fc", 1'b0, 1'b1, 32'h3FC, $urandom);
    model_req("read_hi_alias_255", 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0);
    model_req("read_0x3fc", 1'b1, 1'b0, 32'h3FC, 32'h0);
  endtask

  task automatic test_errors;
    model_req("misaligned_read_0x11", 1'b1, 1'b0, 32'h11, 32'h0);
    model_req("misaligned_write_0x12", 1'b0, 1'b1, 32'h12, 32'h0BAD0BAD);
    model_req("conflict_0x10", 1'b1, 1'b1, 32'h10, 32'h55555555);
    model_req("reread_0x10", 1'b1, 1'b0, 32'h10, 32'h0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      int kind = $urandom_range(0, 9);
      a = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2);
      if (kind == 0) a[1:0] = 2'($urandom_range(1, 3));
      if (kind <= 3)      model_req("rand_write", 1'b0, 1'b1, a, $urandom);
      else if (kind == 9) model_req("rand_conflict", 1'b1, 1'b1, a, $urandom);
      else                model_req("rand_read", 1'b1, 1'b0, a, 32'h0);
    end
  endtask

  task automatic test_held_request;
    int seen = -1;
    @(negedge clk);
    mem_read = 1'b1; addr = 32'h10;
    @(posedge clk); #1;
    for (int k = 0; k < 40; k++) begin
      if (ready) begin seen = k; break; end
      @(posedge clk); #1;
    end
    n_checks++;
    if (seen !== LAT + 1) begin
      n_fail++; $display("FAIL held_first_latency: got %0d expected %0d", seen, LAT + 1);
    end
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || ready !== 1'b0) begin
      n_fail++; $display("FAIL held_idle_gap: busy=%b ready=%b expected 0 0", busy, ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL held_reaccept: busy=%b expected 1", busy);
    end
    mem_read = 1'b0;
    repeat (LAT + 1) @(posedge clk);
    #1;
    n_checks++;
    if (ready !== 1'b1 || rdata !== model_mem[4]) begin
      n_fail++; $display("FAIL held_second_read: ready=%b rdata=%h expected 1 %h", ready, rdata, model_mem[4]);
    end
    model_rdata = model_mem[4]; model_rdata_known = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop;
    int lat; logic e; logic [31:0] q; bit bok, idl;
    issue(1, 1'b0, 1'b1, 32'h20, 32'h11111111, lat, e, q, bok, idl);
    n_checks++;
    if (lat !== LAT3 + 1 || e !== 1'b0) begin
      n_fail++; $display("FAIL lat3_write: latency=%0d err=%b expected %0d 0", lat, e, LAT3 + 1);
    end
    @(negedge clk);
    mem_write_3 = 1'b1; addr_3 = 32'h20; wdata_3 = 32'hCAFEF00D;
    @(posedge clk); #1;
    mem_write_3 = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({ready_3, busy_3, err_3, rdata_3} !== 35'd0 || {ready, busy, err, rdata} !== 35'd0) begin
      n_fail++; $display("FAIL reset_midop_outputs: got %b %b %b %h expected all zero", ready_3, busy_3, err_3, rdata_3);
    end
    @(negedge clk); reset = 1'b0;
    model_rdata = 32'd0; model_rdata_known = 1'b1;
    issue(1, 1'b1, 1'b0, 32'h20, 32'h0, lat, e, q, bok, idl);
    n_checks++;
    if (q !== 32'h11111111 || lat !== LAT3 + 1) begin
      n_fail++; $display("FAIL reset_midop_old_value: got %h latency %0d expected 11111111 %0d", q, lat, LAT3 + 1);
    end
    model_req("post_reset_read_0x0", 1'b1, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wrap();
    test_errors();
    test_random();
    test_held_request();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
